// File: rtl/q_format_pkg.sv
// -----------------------------------------------------------------------------
// q_format_pkg
// Shared helpers for signed Q-format conversion:
//   - aligned()           : rounds a bit width up to a whole number of bytes
//                           (lane pitch inside tdata)
//   - ROUND_* constants   : rounding mode selectors
//   - sat_max()/sat_min() : most positive / most negative two's complement
//                           value of a given width, returned in the low bits
//                           of a 64-bit vector
// -----------------------------------------------------------------------------
package q_format_pkg;

    localparam int ROUND_TRUNC      = 0;
    localparam int ROUND_HALF_UP    = 1;
    localparam int ROUND_CONVERGENT = 2;

    function automatic int aligned(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    // {0,1...1} in the low w bits
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // {1,0...0} in the low w bits
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/q_lane_round_sat.sv
// -----------------------------------------------------------------------------
// q_lane_round_sat
// Combinational datapath of one lane, split at the pipeline register:
//   front half: in_i (Q M_IN.N_IN) -> rnd_o (M_IN+N_OUT+2 bits: sign, carry
//               guard, integer, fraction), rounding per ROUND_MODE
//   back half : rnd_i (registered rnd_o) -> out_o (Q M_OUT.N_OUT), saturated
//               or wrapped per SATURATE
// Ports:
//   in_i   [M_IN+N_IN+1]    input lane value
//   rnd_o  [M_IN+N_OUT+2]   rounded value, to be registered by the parent
//   rnd_i  [M_IN+N_OUT+2]   registered rounded value
//   out_o  [M_OUT+N_OUT+1]  range-limited output value
//   ovf_o  [1]              overflow flag (only with Q_VECTOR_CONVERTER_OVF_FLAG_EN)
// -----------------------------------------------------------------------------
module q_lane_round_sat
    import q_format_pkg::*;
#(
    parameter int M_IN       = 1,
    parameter int N_IN       = 1,
    parameter int M_OUT      = 1,
    parameter int N_OUT      = 1,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SATURATE   = 1
) (
    input  logic [M_IN+N_IN:0]    in_i,
    output logic [M_IN+N_OUT+1:0] rnd_o,
    input  logic [M_IN+N_OUT+1:0] rnd_i,
    output logic [M_OUT+N_OUT:0]  out_o
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
    ,
    output logic                  ovf_o
`endif
);

    localparam int WI = M_IN + N_IN + 1;
    localparam int RW = M_IN + N_OUT + 2;
    localparam int WO = M_OUT + N_OUT + 1;
    localparam int D  = N_IN - N_OUT;

    localparam logic [63:0]   MAX_64 = sat_max(WO);
    localparam logic [63:0]   MIN_64 = sat_min(WO);
    localparam logic [WO-1:0] MAX_V  = MAX_64[WO-1:0];
    localparam logic [WO-1:0] MIN_V  = MIN_64[WO-1:0];

    // ---------------- front half: rounding ----------------
    if (D <= 0) begin : g_expand
        // Gaining fraction bits is exact: sign-extend, then zero-fill below.
        localparam int SH = -D;
        logic signed [RW-1:0] ext;
        assign ext   = RW'($signed(in_i));
        assign rnd_o = ext <<< SH;
    end else begin : g_shrink
        // One extra bit above the sign absorbs the carry that rounding can
        // produce at the positive end.
        logic signed [WI:0] ext;
        logic signed [WI:0] bias;
        logic signed [WI:0] sum;
        assign ext = {in_i[WI-1], in_i};
        if (ROUND_MODE == ROUND_HALF_UP) begin : g_half_up
            assign bias = (WI+1)'(1) << (D - 1);
        end else if (ROUND_MODE == ROUND_CONVERGENT) begin : g_conv
            // Ties round up only when the kept LSB is odd -> ties land on even.
            assign bias = ((WI+1)'(1) << (D - 1)) - (WI+1)'(1) + (WI+1)'(in_i[D]);
        end else begin : g_trunc
            assign bias = '0;
        end
        assign sum   = ext + bias;
        assign rnd_o = RW'(sum >>> D);
    end

    // ---------------- back half: range limiting ----------------
    if (RW > WO) begin : g_narrow
        if (SATURATE != 0) begin : g_sat
            logic ovf;
            // Everything above the output sign must be copies of the true sign.
            assign ovf   = rnd_i[RW-1:WO-1] != {(RW-WO+1){rnd_i[RW-1]}};
            assign out_o = ovf ? (rnd_i[RW-1] ? MIN_V : MAX_V) : rnd_i[WO-1:0];
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
            assign ovf_o = ovf;
`endif
        end else begin : g_wrap
            assign out_o = rnd_i[WO-1:0];
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
            assign ovf_o = rnd_i[RW-1:WO-1] != {(RW-WO+1){rnd_i[RW-1]}};
`else
            logic unused_hi;
            assign unused_hi = ^rnd_i[RW-1:WO];
`endif
        end
    end else begin : g_wide
        // Output range covers every rounded value: plain sign extension.
        assign out_o = WO'($signed(rnd_i));
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
        assign ovf_o = 1'b0;
`endif
    end

endmodule

// File: rtl/q_vector_converter.sv
// -----------------------------------------------------------------------------
// q_vector_converter
// Multi-lane AXI-Stream signed Q-format converter, Q M_IN.N_IN -> Q M_OUT.N_OUT,
// two registered stages (round, range), one beat per cycle, global stall.
// Optional feature macro: Q_VECTOR_CONVERTER_OVF_FLAG_EN (adds m_axis_tuser
// per-lane overflow flags and a saturating 16-bit ovf_count).
// Ports:
//   aclk, aresetn       clock, asynchronous active-low reset
//   s_axis_tdata        LANES lanes, lane k at [k*LW_IN +: LW_IN]
//   s_axis_tvalid/tready/tlast   input handshake
//   m_axis_tdata        LANES lanes, lane k at [k*LW_OUT +: LW_OUT], pad = 0
//   m_axis_tvalid/tready/tlast   output handshake
//   m_axis_tuser        per-lane overflow flag (macro only)
//   ovf_count           beats with any lane overflowed, sticks at 0xFFFF (macro only)
// -----------------------------------------------------------------------------
module q_vector_converter
    import q_format_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int M_IN       = 1,
    parameter int N_IN       = 1,
    parameter int M_OUT      = 1,
    parameter int N_OUT      = 1,
    parameter int ROUND_MODE = ROUND_TRUNC,
    parameter int SATURATE   = 1
) (
    input  logic                                          aclk,
    input  logic                                          aresetn,
    input  logic [LANES*aligned(M_IN+N_IN+1)-1:0]         s_axis_tdata,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic                                          s_axis_tlast,
    output logic [LANES*aligned(M_OUT+N_OUT+1)-1:0]       m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
    output logic [LANES-1:0]                              m_axis_tuser,
    output logic [15:0]                                   ovf_count,
`endif
    output logic                                          m_axis_tlast
);

    localparam int WI     = M_IN + N_IN + 1;
    localparam int RW     = M_IN + N_OUT + 2;
    localparam int WO     = M_OUT + N_OUT + 1;
    localparam int LW_IN  = aligned(WI);
    localparam int LW_OUT = aligned(WO);

    if (ROUND_MODE > ROUND_CONVERGENT) begin : g_bad_round_mode
        $error("q_vector_converter: ROUND_MODE must be 0, 1 or 2");
    end

    logic                    en;
    logic                    s1_valid_q;
    logic                    s1_last_q;
    logic [LANES*RW-1:0]     s1_rnd_d;
    logic [LANES*RW-1:0]     s1_rnd_q;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic [LANES*LW_OUT-1:0] m_data_d;
    logic [LANES*LW_OUT-1:0] m_data_q;
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
    logic [LANES-1:0]        lane_ovf;
    logic [LANES-1:0]        m_user_q;
    logic [15:0]             ovf_cnt_q;
`endif

    // Whole pipeline moves together: it advances whenever the output register
    // is empty or is being drained this cycle.
    assign en            = !m_valid_q || m_axis_tready;
    assign s_axis_tready = aresetn && en;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WI-1:0] in_w;
        logic [WO-1:0] out_w;

        assign in_w = s_axis_tdata[k*LW_IN +: WI];
        if (LW_IN > WI) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^s_axis_tdata[k*LW_IN+WI +: LW_IN-WI];
        end

        q_lane_round_sat #(
            .M_IN       (M_IN),
            .N_IN       (N_IN),
            .M_OUT      (M_OUT),
            .N_OUT      (N_OUT),
            .ROUND_MODE (ROUND_MODE),
            .SATURATE   (SATURATE)
        ) u_lane (
            .in_i  (in_w),
            .rnd_o (s1_rnd_d[k*RW +: RW]),
            .rnd_i (s1_rnd_q[k*RW +: RW]),
            .out_o (out_w)
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
            ,
            .ovf_o (lane_ovf[k])
`endif
        );

        // Zero-extension keeps the lane padding bits at 0.
        assign m_data_d[k*LW_OUT +: LW_OUT] = LW_OUT'(out_w);
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge value of its neighbour; blocking here would let a
    // beat fall through both stages in one edge.
    // NOTE: the datapath registers are reset as well, because tdata must read
    // as zero out of reset and the stages are small flops, not RAM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_rnd_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
        end else if (en) begin
            s1_valid_q <= s_axis_tvalid;
            s1_last_q  <= s_axis_tvalid && s_axis_tlast;
            s1_rnd_q   <= s1_rnd_d;
            m_valid_q  <= s1_valid_q;
            m_last_q   <= s1_last_q;
            m_data_q   <= m_data_d;
        end
    end

`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_user_q  <= '0;
            ovf_cnt_q <= '0;
        end else if (en) begin
            m_user_q <= s1_valid_q ? lane_ovf : '0;
            // Counted as the beat enters the output register, so the count
            // already includes the beat currently presented.
            if (s1_valid_q && (|lane_ovf) && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end
    end

    assign m_axis_tuser = m_user_q;
    assign ovf_count    = ovf_cnt_q;
`endif

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_q_vector_converter.sv
// -----------------------------------------------------------------------------
// tb_q_vector_converter
// Eight two-lane converters with different formats/modes share one input
// stream and one m_axis_tready. Every accepted input beat is logged per
// instance; each output handshake is compared with the value computed from
// the real-number meaning of the input (floor / half-up / half-even, then
// clamp or wrap). Extra directed checks cover reset, latency, throughput
// under backpressure and reset with beats in flight.
// -----------------------------------------------------------------------------
module tb_q_vector_converter;

    localparam int NI    = 8;
    localparam int DEPTH = 4096;

    // Nibbles, top to bottom: M_IN N_IN M_OUT N_OUT ROUND_MODE SATURATE
    function automatic int cfg(input int g, input int f);
        logic [23:0] c;
        case (g)
            0:       c = 24'h341201;
            1:       c = 24'h341211;
            2:       c = 24'h341221;
            3:       c = 24'h341200;
            4:       c = 24'h341210;
            5:       c = 24'h341220;
            6:       c = 24'h123401;
            default: c = 24'h342500;
        endcase
        return int'((c >> (4 * (5 - f))) & 24'hF);
    endfunction

    logic          clk = 1'b0;
    logic          aresetn;
    logic [15:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          m_tready;
    logic [NI-1:0] s_tready;
    logic [NI-1:0] m_tvalid;
    logic [NI-1:0] m_tlast;
    logic [15:0]   m_tdata [NI];
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
    logic [1:0]    m_tuser [NI];
    logic [15:0]   ovf_cnt [NI];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        q_vector_converter #(
            .LANES      (2),
            .M_IN       (cfg(g, 0)),
            .N_IN       (cfg(g, 1)),
            .M_OUT      (cfg(g, 2)),
            .N_OUT      (cfg(g, 3)),
            .ROUND_MODE (cfg(g, 4)),
            .SATURATE   (cfg(g, 5))
        ) u_dut (
            .aclk          (clk),
            .aresetn       (aresetn),
            .s_axis_tdata  (s_tdata),
            .s_axis_tvalid (s_tvalid),
            .s_axis_tready (s_tready[g]),
            .s_axis_tlast  (s_tlast),
            .m_axis_tdata  (m_tdata[g]),
            .m_axis_tvalid (m_tvalid[g]),
            .m_axis_tready (m_tready),
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
            .m_axis_tuser  (m_tuser[g]),
            .ovf_count     (ovf_cnt[g]),
`endif
            .m_axis_tlast  (m_tlast[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: value interpreted as an integer count of 2^-n units, rescaled
    // to 2^-n_out units with the selected rounding, then range-limited.
    function automatic logic [7:0] model(input logic [7:0] b, input int g, output bit ovf);
        int mi, ni, mo, no, mode, sat, wi, wo, v, d, q, rem, half, r, mx, mn;
        mi = cfg(g, 0); ni = cfg(g, 1); mo = cfg(g, 2); no = cfg(g, 3);
        mode = cfg(g, 4); sat = cfg(g, 5);
        wi = mi + ni + 1;
        wo = mo + no + 1;
        v  = int'(b) & ((1 << wi) - 1);
        if (v >= (1 << (wi - 1))) v = v - (1 << wi);
        d = ni - no;
        if (d <= 0) begin
            r = v * (1 << (-d));
        end else begin
            q    = v >>> d;                 // floor(v / 2^d)
            rem  = v - q * (1 << d);        // 0 .. 2^d-1
            half = 1 << (d - 1);
            case (mode)
                0:       r = q;
                1:       r = (rem >= half) ? q + 1 : q;
                default: r = (rem > half || (rem == half && (q % 2) != 0)) ? q + 1 : q;
            endcase
        end
        mx  = (1 << (wo - 1)) - 1;
        mn  = -(1 << (wo - 1));
        ovf = (r > mx) || (r < mn);
        if (ovf && sat != 0) r = (r > mx) ? mx : mn;
        return 8'(r & ((1 << wo) - 1));
    endfunction

    function automatic logic [7:0] mdl(input logic [7:0] b, input int g);
        bit dummy;
        return model(b, g, dummy);
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] log_data [NI][DEPTH];
    logic        log_last [NI][DEPTH];
    int          wr [NI];
    int          rd [NI];
    int          exp_cnt [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            wr[i] = 0; rd[i] = 0; exp_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!aresetn) begin
                    rd[i]      = wr[i];
                    exp_cnt[i] = 0;
                end else begin
                    if (m_tvalid[i]) begin
                        if (rd[i] == wr[i]) begin
                            check($sformatf("spurious_valid_i%0d", i), {31'd0, m_tvalid[i]}, 32'd0);
                        end else if (m_tready) begin
                            logic [15:0] exp_d;
                            logic [1:0]  exp_o;
                            bit          o;
                            for (int l = 0; l < 2; l++) begin
                                exp_d[8*l +: 8] = model(log_data[i][rd[i] % DEPTH][8*l +: 8], i, o);
                                exp_o[l] = o;
                            end
                            check($sformatf("tdata_i%0d_beat%0d", i, rd[i]), {16'd0, m_tdata[i]}, {16'd0, exp_d});
                            check($sformatf("tlast_i%0d_beat%0d", i, rd[i]), {31'd0, m_tlast[i]},
                                  {31'd0, log_last[i][rd[i] % DEPTH]});
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
                            check($sformatf("tuser_i%0d_beat%0d", i, rd[i]), {30'd0, m_tuser[i]}, {30'd0, exp_o});
                            if (exp_o != 2'b00 && exp_cnt[i] < 16'hFFFF) exp_cnt[i]++;
                            check($sformatf("ovf_count_i%0d_beat%0d", i, rd[i]), {16'd0, ovf_cnt[i]}, 32'(exp_cnt[i]));
`endif
                            rd[i]++;
                        end
                    end
                    if (s_tvalid && s_tready[i]) begin
                        log_data[i][wr[i] % DEPTH] = s_tdata;
                        log_last[i][wr[i] % DEPTH] = s_tlast;
                        wr[i]++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] dir_tab [8] = '{16'h0206, 16'hC030, 16'h0A1E, 16'h807F,
                                 16'hFF00, 16'hFA0E, 16'h1A0B, 16'h05F3};

    // pattern 0: tvalid always high, m_tready low on stream cycles 3..5
    // pattern 1: random tvalid gaps and random m_tready
    task automatic send_stream(input int nbeats, input bit directed, input bit rnd, output int cycles);
        int          sent = 0;
        int          cyc  = 0;
        bit          hold = 0;
        bit          acc;
        logic [15:0] cur;
        cur = directed ? dir_tab[0] : 16'($urandom);
        while (sent < nbeats && cyc < 20 * nbeats + 50) begin
            s_tdata  = cur;
            s_tlast  = (sent == nbeats - 1);
            s_tvalid = hold ? 1'b1 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            m_tready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            acc = s_tvalid && s_tready[0];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                hold = 0;
                cur  = directed ? dir_tab[sent % 8] : 16'($urandom);
            end else begin
                hold = s_tvalid;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        check("stream_beats_sent", 32'(sent), 32'(nbeats));
        cycles = cyc;
    endtask

    function automatic int pending();
        int p = 0;
        for (int i = 0; i < NI; i++) p += wr[i] - rd[i];
        return p;
    endfunction

    task automatic drain();
        int n = 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while (pending() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(pending()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int n;

        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;

        // Hand-computed values pin the reference itself.
        check("model_tie_0x06_trunc",    {24'd0, mdl(8'h06, 0)}, 32'h01);
        check("model_tie_0x06_halfup",   {24'd0, mdl(8'h06, 1)}, 32'h02);
        check("model_tie_0x06_conv",     {24'd0, mdl(8'h06, 2)}, 32'h02);
        check("model_tie_0x02_trunc",    {24'd0, mdl(8'h02, 0)}, 32'h00);
        check("model_tie_0x02_halfup",   {24'd0, mdl(8'h02, 1)}, 32'h01);
        check("model_tie_0x02_conv",     {24'd0, mdl(8'h02, 2)}, 32'h00);
        check("model_sat_pos_0x30",      {24'd0, mdl(8'h30, 0)}, 32'h07);
        check("model_sat_neg_0xC0",      {24'd0, mdl(8'hC0, 0)}, 32'h08);
        check("model_carry_sat_0x1E",    {24'd0, mdl(8'h1E, 1)}, 32'h07);
        check("model_wrap_0x30",         {24'd0, mdl(8'h30, 3)}, 32'h0C);
        check("model_expand_0x0A",       {24'd0, mdl(8'h0A, 6)}, 32'hE8);
        check("model_expand_pad_0xFA",   {24'd0, mdl(8'hFA, 6)}, 32'hE8);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_tvalid_i%0d", i), {31'd0, m_tvalid[i]}, 32'd0);
            check($sformatf("rst_tlast_i%0d", i),  {31'd0, m_tlast[i]},  32'd0);
            check($sformatf("rst_tdata_i%0d", i),  {16'd0, m_tdata[i]},  32'd0);
            check($sformatf("rst_tready_i%0d", i), {31'd0, s_tready[i]}, 32'd0);
`ifdef Q_VECTOR_CONVERTER_OVF_FLAG_EN
            check($sformatf("rst_ovf_count_i%0d", i), {16'd0, ovf_cnt[i]}, 32'd0);
`endif
        end
        #1 aresetn = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted beat appears at the second edge after acceptance.
        s_tdata  = 16'h0206;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        while (!m_tvalid[0] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", 32'(n), 32'd2);
        drain();

        // Directed beats with a 3-cycle output stall: 8 beats, 3 stall cycles.
        send_stream(8, 1'b1, 1'b0, cycles);
        check("directed_stream_cycles", 32'(cycles), 32'd11);
        drain();

        // Random traffic and backpressure
        send_stream(400, 1'b0, 1'b1, cycles);
        drain();

        // Reset with two beats in flight
        m_tready = 1'b1;
        s_tdata  = 16'h1E06;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        @(posedge clk);
        #1;
        s_tdata = 16'hC030;
        @(posedge clk);
        #2;
        check("inflight_before_reset", {31'd0, m_tvalid[0]}, 32'd1);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_rst_tvalid_i%0d", i), {31'd0, m_tvalid[i]}, 32'd0);
            check($sformatf("async_rst_tready_i%0d", i), {31'd0, s_tready[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #2 aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_after_reset", {28'd0, 4'(pending())}, 32'd0);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("post_rst_tvalid_i%0d", i), {31'd0, m_tvalid[i]}, 32'd0);
        end
        send_stream(8, 1'b1, 1'b0, cycles);
        check("post_reset_stream_cycles", 32'(cycles), 32'd11);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q_vector_converter.md
Name: q_vector_converter

Overview:
- Multi-lane streaming Q-format converter: each lane converts signed Qm.n to Qm'.n'.
- Selectable rounding: truncate, round-half-up or convergent.
- Selectable overflow policy: saturate or wrap.
- 2-stage registered AXI-Stream pipeline, full throughput; sits between fixed-point DSP stages (filters, NCO, FFT glue) wherever lane formats differ.

Parameters:
LANES, 1, number of independent lanes packed in tdata
M_IN, 1, input integer bits (excl. sign), >=0
N_IN, 1, input fractional bits, >=0
M_OUT, 1, output integer bits (excl. sign), >=0
N_OUT, 1, output fractional bits, >=0
ROUND_MODE, 0, 0=truncate (floor), 1=round half up, 2=convergent (round half to even)
SATURATE, 1, 1=clamp on overflow, 0=wrap (drop upper bits)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  LANES*LW_IN  lane k at [k*LW_IN +: LW_IN], LW_IN=ALIGNED(M_IN+N_IN+1), value in low M_IN+N_IN+1 bits
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  packet end
m_axis_tdata  out  LANES*LW_OUT  lane k at [k*LW_OUT +: LW_OUT], LW_OUT=ALIGNED(M_OUT+N_OUT+1)
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  tlast delayed with its beat

Behaviour:
- Reset (async assert, sync release on aclk): stage-1/stage-2 valids=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; s_axis_tready=0 while aresetn=0.
- Pipeline enable en = !m_axis_tvalid || m_axis_tready; s_axis_tready = aresetn && en. All stages advance only when en=1 (global stall, no bubble collapse).
- Latency: 2 cycles from accepted input beat to m_axis_tvalid with unbroken ready. Throughput 1 beat/cycle.
- Stage 1 (round): D = N_IN-N_OUT.
  - D<=0: left-shift fraction by -D, zero fill; no rounding.
  - D>0: sign-extend the value by 1 bit, then add a bias:
    - mode 0: no bias.
    - mode 1: bias 2^(D-1).
    - mode 2: bias 2^(D-1)-1 + bit D of input (kept LSB).
  - Then arithmetic shift right by D.
  - Result width M_IN+N_OUT+2 (sign, carry guard, integer, fraction); register it.
- Stage 2 (range): compare upper bits against sign.
  - Overflow when the rounded value exceeds the output range; this includes rounding carry (e.g. max input rounded up).
  - SATURATE=1: clamp to max {0,1...1} or min {1,0...0} by true sign.
  - SATURATE=0: keep low M_OUT+N_OUT+1 bits.
  - M_OUT>=M_IN+1 never overflows.
- Output padding bits above M_OUT+N_OUT in each lane are 0. Input padding bits are ignored.
- Lanes are fully independent and share the handshake. tlast travels with its beat.
- Invalid ROUND_MODE (>2) is an elaboration error via a generate-time check.
- Reset mid-stream drops all in-flight beats; no partial output after release.

Optional Feature:
Macro Q_VECTOR_CONVERTER_OVF_FLAG_EN.
- Defined: adds output m_axis_tuser [LANES-1:0], one per-lane overflow flag aligned with its beat (set whether the lane saturated or wrapped). Also adds ovf_count out 16, a saturating count of beats with any lane overflowed. Both reset to 0; ovf_count sticks at 0xFFFF.
- Undefined: neither port exists; no overflow logic beyond what SATURATE needs.

Decomposition:
- Package q_format_pkg:
  - ALIGNED width function
  - ROUND_TRUNC=0 / ROUND_HALF_UP=1 / ROUND_CONVERGENT=2 constants
  - saturation max/min helper functions
- Sub-module q_lane_round_sat: one lane's combinational round + range logic, split at the stage boundary. Instantiate LANES times in a generate loop. The top level owns the handshake and registers.

Test Plan (LANES=1, Q3.4 -> Q1.2 unless stated; tdata hex per lane byte):
- Rounding ties: in 0x06 (0.375) -> mode0 0x01, mode1 0x02, mode2 0x02; in 0x02 (0.125) -> mode0 0x00, mode1 0x01, mode2 0x00.
- Saturation: SATURATE=1, in 0x30 (3.0) -> 0x07; in 0xC0 (-4.0) -> 0x08; in 0x1E (1.875) mode1 -> 0x07 (rounding carry overflow).
- Wrap: SATURATE=0, in 0x30 -> 0x0C (-1.0); with OVF_FLAG_EN, tuser=1 and ovf_count increments 0->1.
- Throughput/backpressure: LANES=2, 8 consecutive beats, m_axis_tready low on cycles 3-5 -> no loss or duplication, order kept, tlast on beat 8 only, first output 2 cycles after first accept.
- Expansion: Q1.2 -> Q3.4, in 0x0A (-1.5) -> 0xE8; padding bits zero.
- Reset: assert aresetn with 2 beats in flight -> m_axis_tvalid=0 immediately (async), no stale beat after release, first new beat correct.
